// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: shared constants, types and helpers for the RV32I
// instruction encoder slice.
//   OPC_OP / OPC_OP_IMM : R-type and I-type ALU opcodes
//   NOP_WORD            : addi x0,x0,0
//   FMT_R / FMT_I       : values of the request format select
//   state_e             : encoder FSM states
//   enc_word()          : packs request fields into a 32-bit word
//   is_legal()          : legality rules for the optional request check
package instr_enc_pkg;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [31:0] NOP_WORD   = 32'h00000013;

    localparam logic FMT_R = 1'b0;
    localparam logic FMT_I = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUBBLE,
        ISSUE
    } state_e;

    function automatic logic [31:0] enc_word(
        input logic        fmt,
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [2:0]  funct3,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [6:0]  funct7,
        input logic [11:0] imm
    );
        if (fmt == FMT_I)
            return {imm, rs1, funct3, rd, opcode};
        else
            return {funct7, rs2, rs1, funct3, rd, opcode};
    endfunction

    // Shift-immediates carry funct7 in imm[11:5], so the I-type rules
    // inspect that slice for funct3 001 (slli) and 101 (srli/srai).
    function automatic logic is_legal(
        input logic        fmt,
        input logic [6:0]  opcode,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [11:0] imm
    );
        logic ok;
        if (fmt == FMT_R) begin
            ok = (opcode == OPC_OP) &&
                 ((funct7 == 7'b0000000) ||
                  ((funct7 == 7'b0100000) &&
                   ((funct3 == 3'b000) || (funct3 == 3'b101))));
        end else begin
            ok = (opcode == OPC_OP_IMM);
            if ((funct3 == 3'b001) && (imm[11:5] != 7'b0000000))
                ok = 1'b0;
            if ((funct3 == 3'b101) &&
                (imm[11:5] != 7'b0000000) && (imm[11:5] != 7'b0100000))
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request and output-stream bundle of the instruction
// encoder.
//   req_*     : field request with valid/ready handshake
//   out_*     : instruction stream towards decode (valid/ready)
//   err       : sticky illegal-request flag
//   level     : FIFO occupancy
// Modports: master = request producer / stream consumer, slave = encoder.
interface instr_encoder_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic             req_valid;
    logic             req_ready;
    logic             req_fmt;
    logic [6:0]       req_opcode;
    logic [4:0]       req_rd;
    logic [2:0]       req_funct3;
    logic [4:0]       req_rs1;
    logic [4:0]       req_rs2;
    logic [6:0]       req_funct7;
    logic [11:0]      req_imm;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_instr;
    logic             err;
    logic [LW-1:0]    level;

    modport master (
        output req_valid, req_fmt, req_opcode, req_rd, req_funct3,
               req_rs1, req_rs2, req_funct7, req_imm, out_ready,
        input  req_ready, out_valid, out_instr, err, level
    );

    modport slave (
        input  req_valid, req_fmt, req_opcode, req_rd, req_funct3,
               req_rs1, req_rs2, req_funct7, req_imm, out_ready,
        output req_ready, out_valid, out_instr, err, level
    );

endinterface

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous DEPTH x WIDTH FIFO.
//   clk, rst     : clock, synchronous active-high reset (clears storage)
//   push, wdata  : write request; ignored while full
//   pop          : read request; ignored while empty
//   rdata        : head word
//   full, empty  : status
//   level        : occupancy, 0..DEPTH
module instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             wr_en;
    logic             rd_en;

    // Pointers carry one extra wrap bit so full and empty are distinct.
    assign level = wr_q - rd_q;
    assign full  = (level == (AW + 1)'(DEPTH));
    assign empty = (wr_q == rd_q);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign rdata = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q[AW-1:0]] <= wdata;
                wr_q                <= wr_q + 1'b1;
            end
            if (rd_en)
                rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: assembles RV32I R/I-type field requests into instruction
// words, inserts GAP NOP bubbles on a RAW hazard against the last issued
// destination register, and streams the words out through a FIFO.
//   clk, rst : clock, synchronous active-high reset
//   bus      : instr_encoder_if.slave (request handshake, output stream,
//              err, level)
// Build option INSTR_ENC_CHECK_EN: enables the request legality check;
// illegal requests complete the handshake, push nothing and set err.
// Without it every request is encoded and err stays 0.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);

    localparam int         LW      = $clog2(DEPTH) + 1;
    localparam logic [2:0] GAP_CNT = 3'(GAP);

    state_e           state_q;
    logic [2:0]       cnt_q;
    logic [WIDTH-1:0] hold_q;
    logic [4:0]       hold_rd_q;
    logic [4:0]       last_rd_q;
    logic             rdy_q;
    logic             err_q;

    logic             full;
    logic             empty;
    logic [LW-1:0]    level;
    logic             accept;
    logic             hazard;
    logic             legal;
    logic             push;
    logic [WIDTH-1:0] new_word;
    logic [WIDTH-1:0] push_word;
    logic [WIDTH-1:0] head_word;

    assign new_word = enc_word(bus.req_fmt, bus.req_opcode, bus.req_rd,
                               bus.req_funct3, bus.req_rs1, bus.req_rs2,
                               bus.req_funct7, bus.req_imm);

    // With GAP = 0 a hazard needs no bubbles, so it takes the direct path.
    assign hazard = (GAP_CNT != 3'd0) && (last_rd_q != 5'd0) &&
                    ((bus.req_rs1 == last_rd_q) ||
                     ((bus.req_fmt == FMT_R) && (bus.req_rs2 == last_rd_q)));

`ifdef INSTR_ENC_CHECK_EN
    assign legal = is_legal(bus.req_fmt, bus.req_opcode, bus.req_funct3,
                            bus.req_funct7, bus.req_imm);
`else
    assign legal = 1'b1;
`endif

    // rdy_q holds req_ready low through reset and for the first cycle of it.
    assign bus.req_ready = rdy_q && (state_q == IDLE) && !full;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        push      = 1'b0;
        push_word = new_word;
        unique case (state_q)
            IDLE:    push = accept && legal && !hazard;
            BUBBLE: begin
                push      = !full;
                push_word = NOP_WORD;
            end
            ISSUE: begin
                push      = !full;
                push_word = hold_q;
            end
            default: push = 1'b0;
        endcase
    end

    // last_rd follows real instructions only: direct pushes update it at
    // accept, held instructions update it when they are finally pushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            hold_rd_q <= '0;
            last_rd_q <= '0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!legal) begin
                            err_q <= 1'b1;
                        end else if (hazard) begin
                            hold_q    <= new_word;
                            hold_rd_q <= bus.req_rd;
                            cnt_q     <= GAP_CNT;
                            state_q   <= BUBBLE;
                        end else begin
                            last_rd_q <= bus.req_rd;
                        end
                    end
                end
                BUBBLE: begin
                    if (!full) begin
                        cnt_q <= cnt_q - 3'd1;
                        if (cnt_q == 3'd1)
                            state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!full) begin
                        last_rd_q <= hold_rd_q;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    instr_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_word),
        .pop   (bus.out_ready),
        .rdata (head_word),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign bus.out_valid = !empty;
    assign bus.out_instr = head_word;
    assign bus.level     = level;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed bench for instr_encoder. Expected words are
// produced by a small reference model when a request is driven and queued;
// a monitor pops and compares them as the DUT emits words. Follows
// INSTR_ENC_CHECK_EN for the legality expectations.
module tb_instr_encoder;
    import instr_enc_pkg::*;

    localparam int GAP   = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if #(.WIDTH(32), .DEPTH(DEPTH)) bus ();

    instr_encoder #(
        .WIDTH (32),
        .DEPTH (DEPTH),
        .GAP   (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [4:0]  m_last_rd = 5'd0;
    logic        m_err     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic m_legal(input logic fmt, input logic [6:0] op,
                                     input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [11:0] imm);
        if (!fmt)
            return (op == 7'b0110011) &&
                   (f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)));
        if (op != 7'b0010011) return 1'b0;
        if (f3 == 3'd1) return imm[11:5] == 7'd0;
        if (f3 == 3'd5) return imm[11:5] == 7'd0 || imm[11:5] == 7'b0100000;
        return 1'b1;
    endfunction

    task automatic set_req(input logic fmt, input logic [6:0] op,
                           input logic [4:0] rd, input logic [2:0] f3,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [6:0] f7, input logic [11:0] imm);
        logic [31:0] w;
        logic        ok;
        logic        hz;
        bus.req_fmt    = fmt;
        bus.req_opcode = op;
        bus.req_rd     = rd;
        bus.req_funct3 = f3;
        bus.req_rs1    = rs1;
        bus.req_rs2    = rs2;
        bus.req_funct7 = f7;
        bus.req_imm    = imm;
        bus.req_valid  = 1'b1;
        if (fmt) w = {imm, rs1, f3, rd, op};
        else     w = {f7, rs2, rs1, f3, rd, op};
`ifdef INSTR_ENC_CHECK_EN
        ok = m_legal(fmt, op, f3, f7, imm);
`else
        ok = 1'b1;
`endif
        if (!ok) begin
            m_err = 1'b1;
        end else begin
            hz = (m_last_rd != 5'd0) &&
                 (rs1 == m_last_rd || (!fmt && rs2 == m_last_rd));
            if (hz) repeat (GAP) exp_q.push_back(32'h00000013);
            exp_q.push_back(w);
            m_last_rd = rd;
        end
    endtask

    task automatic wait_accept(input string tag);
        logic done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.req_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.level == '0 && exp_q.size() == 0) break;
        end
        chk({tag, "_q"}, exp_q.size(), 32'd0);
        chk({tag, "_lvl"}, {29'd0, bus.level}, 32'd0);
        bus.out_ready = 1'b0;
    endtask

    // Compare each emitted word with the queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0)
                chk("sb_unexpected_word", bus.out_instr, 32'hxxxxxxxx);
            else
                chk("sb_word", bus.out_instr, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 0; bus.req_fmt = 0; bus.req_opcode = '0; bus.req_rd = '0;
        bus.req_funct3 = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
        bus.req_funct7 = '0; bus.req_imm = '0; bus.out_ready = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_level", {29'd0, bus.level}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

        // add x3,x1,x2: visible right after the accepting edge
        set_req(FMT_R, OPC_OP, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 12'd0);
        wait_accept("acc_add");
        chk("add_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("add_word", bus.out_instr, 32'h002081B3);
        drain("drain_add");

        // addi x5,x0,-1
        set_req(FMT_I, OPC_OP_IMM, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 12'hFFF);
        wait_accept("acc_addi");
        chk("addi_word", bus.out_instr, 32'hFFF00293);
        drain("drain_addi");

        // addi x5 then add x6,x5,x5: two bubbles, then the held add
        set_req(FMT_I, OPC_OP_IMM, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 12'hFFF);
        wait_accept("acc_haz0");
        set_req(FMT_R, OPC_OP, 5'd6, 3'd0, 5'd5, 5'd5, 7'd0, 12'd0);
        wait_accept("acc_haz1");
        chk("haz_ready_bubble", {31'd0, bus.req_ready}, 32'd0);
        chk("haz_lvl1", {29'd0, bus.level}, 32'd1);
        tick();
        chk("haz_lvl2", {29'd0, bus.level}, 32'd2);
        tick();
        chk("haz_lvl3", {29'd0, bus.level}, 32'd3);
        tick();
        chk("haz_lvl4", {29'd0, bus.level}, 32'd4);
        chk("haz_head", bus.out_instr, 32'hFFF00293);
        drain("drain_haz");

        // rd=0 pair: no bubbles
        set_req(FMT_I, OPC_OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 12'hFFF);
        wait_accept("acc_rd0_a");
        set_req(FMT_R, OPC_OP, 5'd6, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0);
        wait_accept("acc_rd0_b");
        tick();
        chk("rd0_lvl", {29'd0, bus.level}, 32'd2);
        chk("rd0_ready", {31'd0, bus.req_ready}, 32'd1);
        drain("drain_rd0");

        // I-type whose imm[4:0] equals last_rd is no hazard; rs2-only R hazard is
        set_req(FMT_I, OPC_OP_IMM, 5'd7, 3'd0, 5'd1, 5'd6, 7'd0, 12'd6);
        wait_accept("acc_immrd");
        chk("immrd_lvl", {29'd0, bus.level}, 32'd1);
        set_req(FMT_R, OPC_OP, 5'd8, 3'd0, 5'd0, 5'd7, 7'd0, 12'd0);
        wait_accept("acc_rs2haz");
        repeat (3) tick();
        chk("rs2haz_lvl", {29'd0, bus.level}, 32'd4);
        drain("drain_rs2haz");

        // Five back-to-back with the consumer stalled
        for (int k = 0; k < 4; k++) begin
            set_req(FMT_I, OPC_OP_IMM, 5'(10 + k), 3'd0, 5'd0, 5'd0, 7'd0, 12'(k + 1));
            wait_accept("acc_fill");
            chk("fill_lvl", {29'd0, bus.level}, 32'(k + 1));
        end
        chk("full_ready", {31'd0, bus.req_ready}, 32'd0);
        set_req(FMT_I, OPC_OP_IMM, 5'd14, 3'd0, 5'd0, 5'd0, 7'd0, 12'd5);
        tick();
        tick();
        chk("full_hold_lvl", {29'd0, bus.level}, 32'd4);
        chk("full_hold_ready", {31'd0, bus.req_ready}, 32'd0);
        bus.out_ready = 1'b1;
        wait_accept("acc_fifth");
        chk("pushpop_lvl", {29'd0, bus.level}, 32'd3);
        drain("drain_five");

        // funct7=0000001 R-type, plus shift-immediate legality cases
        set_req(FMT_R, OPC_OP, 5'd3, 3'd0, 5'd1, 5'd2, 7'b0000001, 12'd0);
        wait_accept("acc_f7");
`ifdef INSTR_ENC_CHECK_EN
        chk("f7_err", {31'd0, bus.err}, 32'd1);
        chk("f7_lvl", {29'd0, bus.level}, 32'd0);
`else
        chk("f7_word", bus.out_instr, 32'h022081B3);
        chk("f7_err", {31'd0, bus.err}, 32'd0);
`endif
        set_req(FMT_I, OPC_OP_IMM, 5'd9, 3'd0, 5'd0, 5'd0, 7'd0, 12'd1);
        wait_accept("acc_legal");
        chk("sticky_err", {31'd0, bus.err}, {31'd0, m_err});
        chk("legal_lvl", {29'd0, bus.level}, exp_q.size());
        set_req(FMT_I, OPC_OP_IMM, 5'd4, 3'd1, 5'd0, 5'd0, 7'd0, {7'h01, 5'd3});
        wait_accept("acc_slli_bad");
        chk("slli_bad_lvl", {29'd0, bus.level}, exp_q.size());
        set_req(FMT_I, OPC_OP_IMM, 5'd4, 3'd5, 5'd0, 5'd0, 7'd0, {7'h20, 5'd3});
        wait_accept("acc_srai");
        chk("srai_lvl", {29'd0, bus.level}, exp_q.size());
        chk("chk_err", {31'd0, bus.err}, {31'd0, m_err});
        drain("drain_chk");

        // Reset during BUBBLE discards the held instruction
        set_req(FMT_I, OPC_OP_IMM, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 12'hFFF);
        wait_accept("acc_rb0");
        set_req(FMT_R, OPC_OP, 5'd6, 3'd0, 5'd5, 5'd5, 7'd0, 12'd0);
        wait_accept("acc_rb1");
        tick();
        chk("rb_lvl_before", {29'd0, bus.level}, 32'd2);
        rst = 1'b1;
        tick();
        chk("rb_lvl", {29'd0, bus.level}, 32'd0);
        chk("rb_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rb_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rb_instr", bus.out_instr, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        m_last_rd = 5'd0;
        m_err     = 1'b0;
        tick();
        chk("rb_ready_after", {31'd0, bus.req_ready}, 32'd1);
        chk("rb_err", {31'd0, bus.err}, 32'd0);
        bus.out_ready = 1'b1;
        repeat (4) tick();
        chk("rb_no_emit", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b0;

        // last_rd cleared by reset: same add raises no hazard
        set_req(FMT_R, OPC_OP, 5'd6, 3'd0, 5'd5, 5'd5, 7'd0, 12'd0);
        wait_accept("acc_post_rb");
        tick();
        chk("post_rb_lvl", {29'd0, bus.level}, 32'd1);
        drain("drain_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
